// File: rtl/seg7_capture.sv
// Recovers the hex digits shown on a multiplexed 7-segment display by sampling its drive lines.
// Optional feature: define SEG7_CAPTURE_DP_EN to also capture the decimal point per digit.
module seg7_capture #(
    parameter int MODULES       = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  a_to_g,
    input  logic        dp,
    input  logic [3:0]  an_l,
    input  logic [3:0]  an_h,
    input  logic        err_clr,
    output logic [15:0] x_l,
    output logic [15:0] x_h,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic [7:0]  dp_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HELD   = 2'd2;

    localparam logic [7:0] CAPTURE_AT = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ENABLED    = (MODULES == 2) ? 8'hFF : 8'h0F;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    logic [6:0] seg_p0, seg_p1;
    logic [7:0] an_p0, an_p1;
    logic       dp_bit;

    // Two-flop synchronizer stage; presets to all-ones so nothing looks active
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_p0 <= '1;
            seg_p1 <= '1;
            an_p0  <= '1;
            an_p1  <= '1;
        end else begin
            seg_p0 <= a_to_g;
            seg_p1 <= seg_p0;
            an_p0  <= {an_h, an_l};
            an_p1  <= an_p0;
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic dp_p0, dp_p1;
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_p0 <= 1'b1;
            dp_p1 <= 1'b1;
        end else begin
            dp_p0 <= dp;
            dp_p1 <= dp_p0;
        end
    end
    assign dp_bit = dp_p1;
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign dp_bit    = 1'b1;
`endif

    logic [7:0] low;
    logic       active;
    logic [2:0] idx;

    always_comb begin
        low = ~an_p1;
        if (MODULES != 2) low[7:4] = 4'b0;
        active = (low != 8'd0) && ((low & (low - 8'd1)) == 8'd0);
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (low[i]) idx = 3'(i);
        end
    end

    logic [10:0] cur_key, prev_key;
    logic        stable;
    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        capture;

    assign cur_key = {dp_bit, seg_p1, idx};
    assign stable  = (cur_key == prev_key);
    assign capture = (state == SETTLE) && active && stable && (cnt == CAPTURE_AT);

    // Dwell tracking: count consecutive identical samples, capture once per dwell
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            prev_key <= '1;
        end else begin
            prev_key <= cur_key;
            case (state)
                IDLE: begin
                    if (active) begin
                        state <= SETTLE;
                        cnt   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!active) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (!stable) begin
                        cnt <= 8'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CAPTURE_AT) state <= HELD;
                    end
                end
                HELD: begin
                    if (!active) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (!stable) begin
                        state <= SETTLE;
                        cnt   <= 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    logic [4:0]  dec;
    logic        blank;
    logic [7:0]  cap_bit;
    logic [7:0]  mask;
    logic [31:0] digits;
    logic        mask_full;

    assign dec       = decode(seg_p1);
    assign blank     = (seg_p1 == 7'h7F);
    assign cap_bit   = (capture && dec[4]) ? (8'd1 << idx) : 8'd0;
    assign mask_full = (mask == ENABLED);

    // Capture stage: digit store, frame tracking and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= 32'd0;
            digit_valid <= 8'd0;
            mask        <= 8'd0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            if (capture && dec[4]) begin
                digits[{idx, 2'b00} +: 4] <= dec[3:0];
                digit_valid[idx]          <= 1'b1;
            end
            frame_done <= mask_full;
            mask       <= (mask_full ? 8'd0 : mask) | cap_bit;
            if (err_clr)
                pattern_err <= 1'b0;
            else if (capture && !dec[4] && !blank)
                pattern_err <= 1'b1;
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic [7:0] dp_reg;
    always_ff @(posedge clk) begin
        if (reset)
            dp_reg <= 8'd0;
        else if (capture && (dec[4] || blank))
            dp_reg[idx] <= ~dp_bit;
    end
    assign dp_out = dp_reg;
`else
    assign dp_out = 8'd0;
`endif

    assign x_l = digits[15:0];
    assign x_h = (MODULES == 2) ? digits[31:16] : 16'd0;

endmodule
